// File: rtl/regbank_operand_stage.sv
// regbank_operand_stage
//   RV32I register bank (NREGS x XLEN) feeding the ID/EX operand register
//   that drives the ALU srcA/srcB inputs.
//
//   Optional feature macro: REGBANK_BYPASS_EN
//     defined   : a same-cycle writeback to rs1/rs2 (rd!=0) is forwarded to the read data
//     undefined : reads return the pre-write value (hazard unit must stall)
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   id_valid            decode slot valid
//   rs1, rs2            source register addresses
//   imm                 sign-extended immediate
//   alu_src_imm         1: srcB = imm, 0: srcB = regs[rs2]
//   stall, flush        hold / bubble the operand register (flush wins)
//   we, rd, wd          writeback port
//   srcA, srcB          registered operands to the ALU
//   ex_valid            srcA/srcB carry a valid instruction
module regbank_operand_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src_imm,
    input  logic            stall,
    input  logic            flush,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] srcA,
    output logic [XLEN-1:0] srcB,
    output logic            ex_valid
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] rdata1, rdata2;
    logic [XLEN-1:0] srca_q, srca_d;
    logic [XLEN-1:0] srcb_q, srcb_d;
    logic            vld_q, vld_d;
    logic            wr_en;

    // x0 is never written, so its storage stays at the reset value.
    assign wr_en = we && (rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[rd] <= wd;
        end
    end

    // Combinational read; address 0 forced to zero regardless of storage.
    always_comb begin
        rdata1 = (rs1 == '0) ? '0 : regs_q[rs1];
        rdata2 = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef REGBANK_BYPASS_EN
        // Write-through: wr_en already excludes rd=0, so x0 is never forwarded.
        if (wr_en && (rd == rs1)) rdata1 = wd;
        if (wr_en && (rd == rs2)) rdata2 = wd;
`endif
    end

    // Operand register next state: flush > stall > capture.
    always_comb begin
        srca_d = srca_q;
        srcb_d = srcb_q;
        vld_d  = vld_q;
        if (flush) begin
            srca_d = '0;
            srcb_d = '0;
            vld_d  = 1'b0;
        end else if (!stall) begin
            srca_d = rdata1;
            srcb_d = alu_src_imm ? imm : rdata2;
            vld_d  = id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srca_q <= '0;
            srcb_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            srca_q <= srca_d;
            srcb_q <= srcb_d;
            vld_q  <= vld_d;
        end
    end

    assign srcA     = srca_q;
    assign srcB     = srcb_q;
    assign ex_valid = vld_q;

endmodule
